// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu between two requesters.
// Operands are captured on grant, the result is registered and held until the owner accepts it.

module alu #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic signed [NB_DATA-1:0] a,
  input  logic signed [NB_DATA-1:0] b,
  input  logic        [NB_OP-1:0]   op,
  output logic signed [NB_DATA-1:0] result
);

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

  logic [NB_DATA-1:0] a_u;
  logic [NB_DATA-1:0] b_u;

  assign a_u = a;
  assign b_u = b;

  // Carry and overflow are dropped: every result is truncated to NB_DATA bits.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SRA:  result = a >>> b_u;
      OP_SRL:  result = a_u >> b_u;
      default: result = '0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_valid_0,
  input  logic [NB_DATA-1:0] i_a_0,
  input  logic [NB_DATA-1:0] i_b_0,
  input  logic [NB_OP-1:0]   i_op_0,
  output logic               o_ready_0,
  output logic               o_res_valid_0,
  input  logic               i_res_ready_0,
  input  logic               i_valid_1,
  input  logic [NB_DATA-1:0] i_a_1,
  input  logic [NB_DATA-1:0] i_b_1,
  input  logic [NB_OP-1:0]   i_op_1,
  output logic               o_ready_1,
  output logic               o_res_valid_1,
  input  logic               i_res_ready_1,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_busy,
  output logic               o_grant
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_t;

  state_t state;
  state_t state_next;

  logic grant;
  logic grant_next;
  logic prio;
  logic prio_next;
  logic load_en;
  logic valid_g;
  logic res_ready_g;
  logic winner;

  logic signed [NB_DATA-1:0] a_reg;
  logic signed [NB_DATA-1:0] b_reg;
  logic        [NB_OP-1:0]   op_reg;
  logic signed [NB_DATA-1:0] alu_out;
  logic signed [NB_DATA-1:0] result_reg;

  assign valid_g     = grant ? i_valid_1 : i_valid_0;
  assign res_ready_g = grant ? i_res_ready_1 : i_res_ready_0;
  // The priority holder wins if it asks; otherwise the other requester takes the slot.
  assign winner      = (prio ? i_valid_1 : i_valid_0) ? prio : ~prio;

  always_comb begin
    state_next = state;
    grant_next = grant;
    prio_next  = prio;
    load_en    = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid_0 || i_valid_1) begin
          grant_next = winner;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (valid_g) begin
          load_en    = 1'b1;
          state_next = EXEC;
        end else begin
          state_next = IDLE;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (res_ready_g) begin
          prio_next  = ~grant;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      prio       <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      prio  <= prio_next;
      if (load_en) begin
        a_reg  <= grant ? i_a_1  : i_a_0;
        b_reg  <= grant ? i_b_1  : i_b_0;
        op_reg <= grant ? i_op_1 : i_op_0;
      end
      if (state == EXEC) begin
        result_reg <= alu_out;
      end
    end
  end

  alu #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .op     (op_reg),
    .result (alu_out)
  );

  assign o_ready_0     = load_en & ~grant;
  assign o_ready_1     = load_en & grant;
  assign o_res_valid_0 = (state == RESP) & ~grant;
  assign o_res_valid_1 = (state == RESP) & grant;
  assign o_result      = result_reg;
  assign o_busy        = (state != IDLE);
  assign o_grant       = grant;

endmodule
